// File: rtl/nzp_ben_stack.sv
// nzp_ben_stack
// Condition-code (N/Z/P) and branch-enable unit with a bounded CC save stack.
//
// NZP is derived from a DATA_W-bit bus value and loaded on LD_CC. BEN is
// loaded on LD_BEN from the IR[11:9] mask ANDed with either the registered
// NZP (BYPASS=0) or the NZP being loaded at the same edge (BYPASS=1).
// CC_PUSH saves the registered NZP on a LIFO; CC_POP restores it.
//
// Ports:
//   Clk      in   rising-edge clock
//   Reset    in   asynchronous active-low reset
//   bus      in   [DATA_W-1:0] datapath bus value
//   IR11     in   [2:0] branch mask {n,z,p}
//   LD_CC    in   load NZP from bus
//   LD_BEN   in   load BEN register
//   CC_PUSH  in   push registered NZP onto the save stack
//   CC_POP   in   restore NZP from top of the save stack
//   CLR_ERR  in   clear sticky stack error flags
//   NZP      out  [2:0] registered condition code {N,Z,P}
//   BEN_out  out  registered branch enable
//   CC_DEPTH out  [$clog2(DEPTH+1)-1:0] entries on stack
//   STK_OVF  out  sticky: push attempted while full
//   STK_UNF  out  sticky: pop attempted while empty
module nzp_ben_stack #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 4,
   parameter bit BYPASS = 1'b0,
   localparam int DW    = $clog2(DEPTH + 1)
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [DATA_W-1:0] bus,
   input  logic [2:0]        IR11,
   input  logic              LD_CC,
   input  logic              LD_BEN,
   input  logic              CC_PUSH,
   input  logic              CC_POP,
   input  logic              CLR_ERR,
   output logic [2:0]        NZP,
   output logic              BEN_out,
   output logic [DW-1:0]     CC_DEPTH,
   output logic              STK_OVF,
   output logic              STK_UNF
);

   logic [2:0]    nzp_q,   nzp_d;
   logic          ben_q,   ben_d;
   logic [DW-1:0] depth_q, depth_d;
   logic          ovf_q,   ovf_d;
   logic          unf_q,   unf_d;
   logic [2:0]    stack_q [DEPTH];
   logic [2:0]    stack_d [DEPTH];

   logic [2:0] nzp_next;
   logic [2:0] top_entry;
   logic [2:0] ben_src;
   logic       push_only, pop_only;
   logic       full, empty;

   // Condition code from the bus; always one-hot.
   always_comb begin
      nzp_next = 3'b001;
      if (bus[DATA_W-1])
         nzp_next = 3'b100;
      else if (bus == '0)
         nzp_next = 3'b010;
   end

   // A simultaneous push and pop cancel out entirely (no restore, no error).
   assign push_only = CC_PUSH & ~CC_POP;
   assign pop_only  = CC_POP & ~CC_PUSH;
   assign full      = (depth_q == DW'(DEPTH));
   assign empty     = (depth_q == '0);

   // Top-of-stack read, only meaningful when not empty.
   always_comb begin
      top_entry = nzp_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (DW'(i) == depth_q - DW'(1))
            top_entry = stack_q[i];
      end
   end

   always_comb begin
      nzp_d   = nzp_q;
      depth_d = depth_q;
      stack_d = stack_q;
      ovf_d   = ovf_q & ~CLR_ERR;
      unf_d   = unf_q & ~CLR_ERR;

      if (push_only) begin
         if (full) begin
            ovf_d = 1'b1;
         end else begin
            // Pushed value is always the registered NZP, even alongside LD_CC.
            for (int i = 0; i < DEPTH; i++) begin
               if (DW'(i) == depth_q)
                  stack_d[i] = nzp_q;
            end
            depth_d = depth_q + DW'(1);
         end
      end

      if (pop_only) begin
         if (empty) begin
            unf_d = 1'b1;
         end else begin
            nzp_d   = top_entry;
            depth_d = depth_q - DW'(1);
         end
      end

      // LD_CC overrides any popped value; the pop still discards its entry.
      if (LD_CC)
         nzp_d = nzp_next;
   end

   always_comb begin
      ben_src = BYPASS ? nzp_d : nzp_q;
      ben_d   = LD_BEN ? |(IR11 & ben_src) : ben_q;
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         nzp_q   <= 3'b010;
         ben_q   <= 1'b0;
         depth_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         nzp_q   <= nzp_d;
         ben_q   <= ben_d;
         depth_q <= depth_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   // Stack contents are don't-care after reset; CC_DEPTH alone marks validity.
   always_ff @(posedge Clk) begin
      stack_q <= stack_d;
   end

   assign NZP      = nzp_q;
   assign BEN_out  = ben_q;
   assign CC_DEPTH = depth_q;
   assign STK_OVF  = ovf_q;
   assign STK_UNF  = unf_q;

endmodule

// File: tb/tb_nzp_ben_stack.sv
// Bench for nzp_ben_stack: three instances share control inputs
//   u0: DATA_W=16, DEPTH=4, BYPASS=0
//   u1: DATA_W=16, DEPTH=4, BYPASS=1
//   u2: DATA_W=8,  DEPTH=2, BYPASS=0
// Each cycle the driver pushes the model's view of all three instances'
// outputs into exp_q, then applies new inputs; the monitor pops on every
// falling edge and compares.
module tb_nzp_ben_stack;

   logic        Clk = 1'b0;
   logic        Reset = 1'b0;
   logic [15:0] bus16 = '0;
   logic [7:0]  bus8 = '0;
   logic [2:0]  IR11 = '0;
   logic        LD_CC = 0, LD_BEN = 0, CC_PUSH = 0, CC_POP = 0, CC_CLR = 0;

   logic [2:0] nzp0, nzp1, nzp2;
   logic       ben0, ben1, ben2;
   logic [2:0] dep0, dep1;
   logic [1:0] dep2;
   logic       ovf0, ovf1, ovf2, unf0, unf1, unf2;

   always #5 Clk = ~Clk;

   nzp_ben_stack #(.DATA_W(16), .DEPTH(4), .BYPASS(1'b0)) u0 (
      .Clk(Clk), .Reset(Reset), .bus(bus16), .IR11(IR11), .LD_CC(LD_CC),
      .LD_BEN(LD_BEN), .CC_PUSH(CC_PUSH), .CC_POP(CC_POP), .CLR_ERR(CC_CLR),
      .NZP(nzp0), .BEN_out(ben0), .CC_DEPTH(dep0), .STK_OVF(ovf0), .STK_UNF(unf0));

   nzp_ben_stack #(.DATA_W(16), .DEPTH(4), .BYPASS(1'b1)) u1 (
      .Clk(Clk), .Reset(Reset), .bus(bus16), .IR11(IR11), .LD_CC(LD_CC),
      .LD_BEN(LD_BEN), .CC_PUSH(CC_PUSH), .CC_POP(CC_POP), .CLR_ERR(CC_CLR),
      .NZP(nzp1), .BEN_out(ben1), .CC_DEPTH(dep1), .STK_OVF(ovf1), .STK_UNF(unf1));

   nzp_ben_stack #(.DATA_W(8), .DEPTH(2), .BYPASS(1'b0)) u2 (
      .Clk(Clk), .Reset(Reset), .bus(bus8), .IR11(IR11), .LD_CC(LD_CC),
      .LD_BEN(LD_BEN), .CC_PUSH(CC_PUSH), .CC_POP(CC_POP), .CLR_ERR(CC_CLR),
      .NZP(nzp2), .BEN_out(ben2), .CC_DEPTH(dep2), .STK_OVF(ovf2), .STK_UNF(unf2));

   // ---------------- scoreboard ----------------
   localparam int W = 27;  // 3 x {nzp[3], ben, depth[3], ovf, unf}
   logic [W-1:0] exp_q[$];
   int n_cmp = 0;
   int n_bad = 0;

   // ---------------- reference model ----------------
   logic [2:0] m_nzp [3];
   logic       m_ben [3];
   int         m_cnt [3];
   logic       m_ovf [3];
   logic       m_unf [3];
   logic [2:0] m_stk [3][8];

   function automatic logic [W-1:0] dut_pack();
      return {nzp0, ben0, dep0, ovf0, unf0,
              nzp1, ben1, dep1, ovf1, unf1,
              nzp2, ben2, {1'b0, dep2}, ovf2, unf2};
   endfunction

   function automatic logic [W-1:0] model_pack();
      logic [W-1:0] r;
      for (int k = 0; k < 3; k++)
         r[W-1-9*k -: 9] = {m_nzp[k], m_ben[k], 3'(m_cnt[k]), m_ovf[k], m_unf[k]};
      return r;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         m_nzp[k] = 3'b010;
         m_ben[k] = 1'b0;
         m_cnt[k] = 0;
         m_ovf[k] = 1'b0;
         m_unf[k] = 1'b0;
      end
   endtask

   // Applies one clock of the architectural rules to every modelled instance.
   task automatic model_update(input logic [15:0] b16, input logic [7:0] b8,
                               input logic [2:0] ir, input logic ld_cc,
                               input logic ld_ben, input logic push,
                               input logic pop, input logic clr);
      for (int k = 0; k < 3; k++) begin
         int         depth_max;
         int         val;
         logic [2:0] from_bus;
         logic [2:0] new_nzp;
         logic       ovf_evt, unf_evt;
         depth_max = (k == 2) ? 2 : 4;
         val = (k == 2) ? int'($signed(b8)) : int'($signed(b16));
         from_bus = (val < 0) ? 3'b100 : (val == 0) ? 3'b010 : 3'b001;
         new_nzp = m_nzp[k];
         ovf_evt = 1'b0;
         unf_evt = 1'b0;
         if (push && !pop) begin
            if (m_cnt[k] == depth_max) ovf_evt = 1'b1;
            else begin
               m_stk[k][m_cnt[k]] = m_nzp[k];
               m_cnt[k]++;
            end
         end
         if (pop && !push) begin
            if (m_cnt[k] == 0) unf_evt = 1'b1;
            else begin
               m_cnt[k]--;
               new_nzp = m_stk[k][m_cnt[k]];
            end
         end
         if (ld_cc) new_nzp = from_bus;
         if (ld_ben) m_ben[k] = |(ir & ((k == 1) ? new_nzp : m_nzp[k]));
         m_nzp[k] = new_nzp;
         if (clr) begin
            m_ovf[k] = 1'b0;
            m_unf[k] = 1'b0;
         end
         if (ovf_evt) m_ovf[k] = 1'b1;
         if (unf_evt) m_unf[k] = 1'b1;
      end
   endtask

   // ---------------- driver ----------------
   task automatic step(input logic [15:0] b16, input logic [7:0] b8,
                       input logic [2:0] ir, input logic ld_cc,
                       input logic ld_ben, input logic push,
                       input logic pop, input logic clr);
      @(posedge Clk);
      #1;
      exp_q.push_back(model_pack());
      bus16 = b16; bus8 = b8; IR11 = ir;
      LD_CC = ld_cc; LD_BEN = ld_ben; CC_PUSH = push; CC_POP = pop; CC_CLR = clr;
      model_update(b16, b8, ir, ld_cc, ld_ben, push, pop, clr);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         step(16'h0, 8'h0, 3'b000, 0, 0, 0, 0, 0);
   endtask

   // ---------------- monitor ----------------
   always @(negedge Clk) begin
      if (exp_q.size() != 0) begin
         logic [W-1:0] e, a;
         e = exp_q.pop_front();
         a = dut_pack();
         for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (a[W-1-9*k -: 9] !== e[W-1-9*k -: 9]) begin
               n_bad++;
               $display("FAIL state u%0d {nzp,ben,depth,ovf,unf} @%0t: got %b want %b",
                        k, $time, a[W-1-9*k -: 9], e[W-1-9*k -: 9]);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [W-1:0] rst_exp;
      model_reset();
      repeat (2) @(negedge Clk);
      #2 Reset = 1'b1;

      // Bus decoding then BEN from registered NZP.
      step(16'h8000, 8'h80, 3'b000, 1, 0, 0, 0, 0);
      step(16'h0000, 8'h00, 3'b000, 1, 0, 0, 0, 0);
      step(16'h0001, 8'h7F, 3'b000, 1, 0, 0, 0, 0);
      step(16'h0000, 8'h00, 3'b001, 0, 1, 0, 0, 0);
      step(16'h0000, 8'h00, 3'b110, 0, 1, 0, 0, 0);

      // BYPASS contrast: NZP=010, then LD_CC (negative) + LD_BEN mask 100.
      step(16'h0000, 8'h00, 3'b000, 1, 0, 0, 0, 0);
      step(16'hFFFF, 8'hFF, 3'b100, 1, 1, 0, 0, 0);
      step(16'h0000, 8'h00, 3'b100, 0, 1, 0, 0, 0);

      // Fill stack with 100,010,001,100; fifth push overflows.
      step(16'h8000, 8'h80, 3'b000, 1, 0, 0, 0, 0);
      step(16'h0000, 8'h00, 3'b000, 0, 0, 1, 0, 0);
      step(16'h0000, 8'h00, 3'b000, 1, 0, 0, 0, 0);
      step(16'h0000, 8'h00, 3'b000, 0, 0, 1, 0, 0);
      step(16'h1234, 8'h12, 3'b000, 1, 0, 0, 0, 0);
      step(16'h0000, 8'h00, 3'b000, 0, 0, 1, 0, 0);
      step(16'hA000, 8'hA0, 3'b000, 1, 0, 0, 0, 0);
      step(16'h0000, 8'h00, 3'b000, 0, 0, 1, 0, 0);
      step(16'h0000, 8'h00, 3'b000, 0, 0, 1, 0, 0);
      // Four pops, fifth underflows, then clear flags.
      for (int i = 0; i < 5; i++)
         step(16'h0000, 8'h00, 3'b000, 0, 0, 0, 1, 0);
      step(16'h0000, 8'h00, 3'b000, 0, 0, 0, 0, 1);

      // Simultaneous events at depth 2.
      step(16'h8000, 8'h80, 3'b000, 1, 0, 0, 0, 0);
      step(16'h0000, 8'h00, 3'b000, 0, 0, 1, 0, 0);
      step(16'h0005, 8'h05, 3'b000, 1, 0, 0, 0, 0);
      step(16'h0000, 8'h00, 3'b000, 0, 0, 1, 0, 0);
      step(16'h0000, 8'h00, 3'b000, 0, 0, 1, 1, 0);
      step(16'h0000, 8'h00, 3'b000, 1, 0, 0, 1, 0);
      step(16'hC000, 8'hC0, 3'b000, 1, 0, 1, 0, 0);
      // Error event with CLR_ERR in the same cycle keeps the flag.
      step(16'h0000, 8'h00, 3'b000, 0, 0, 0, 1, 0);
      step(16'h0000, 8'h00, 3'b000, 0, 0, 0, 1, 0);
      step(16'h0000, 8'h00, 3'b000, 0, 0, 0, 1, 0);
      step(16'h0000, 8'h00, 3'b000, 1, 0, 0, 1, 1);
      step(16'h7000, 8'h70, 3'b111, 0, 1, 1, 0, 0);
      idle(2);

      // Asynchronous reset pulse mid-cycle, checked before any clock edge.
      @(negedge Clk);
      #2 Reset = 1'b0;
      #1;
      rst_exp = {3{9'b010_0_000_0_0}};
      for (int k = 0; k < 3; k++) begin
         n_cmp++;
         if (dut_pack()[W-1-9*k -: 9] !== rst_exp[W-1-9*k -: 9]) begin
            n_bad++;
            $display("FAIL async_reset u%0d: got %b want %b",
                     k, dut_pack()[W-1-9*k -: 9], rst_exp[W-1-9*k -: 9]);
         end
      end
      model_reset();
      @(negedge Clk);
      #2 Reset = 1'b1;

      // Randomized traffic with a bias toward stack activity.
      for (int i = 0; i < 600; i++) begin
         logic [15:0] b16;
         logic [7:0]  b8;
         int sel;
         sel = $urandom_range(0, 3);
         b16 = (sel == 0) ? 16'h0 : (sel == 1) ? (16'h8000 | 16'($urandom)) : 16'($urandom);
         sel = $urandom_range(0, 3);
         b8  = (sel == 0) ? 8'h0 : (sel == 1) ? (8'h80 | 8'($urandom)) : 8'($urandom);
         step(b16, b8, 3'($urandom),
              ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 0),
              ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
              ($urandom_range(0, 9) == 0));
      end
      idle(2);

      repeat (3) @(negedge Clk);
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
